// File: rtl/ddr2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_pkg
// Description : Shared DDR2 command encodings, mode-register selects and
//               address bit positions.
// Revision    : 1.0
// ============================================================================
package ddr2_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LM   = 4'b0000;

    // Encoding equals the bank address used to load each register
    typedef enum logic [1:0] {
        SEL_MR   = 2'd0,
        SEL_EMR1 = 2'd1,
        SEL_EMR2 = 2'd2,
        SEL_EMR3 = 2'd3
    } mr_sel_e;

    localparam int A8_DLL_RST = 8;
    localparam int A10_AP     = 10;
    localparam int A9_7_OCD   = 7;
    localparam int OCD_W      = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_cmd_timer
// Description : Loadable down-counter with zero flag for command spacing.
// Revision    : 1.0
// ============================================================================
module ddr2_cmd_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_init_seq
// Description : DDR2 power-up initialisation sequencer with runtime
//               mode-register update channel and re-initialisation.
// Revision    : 1.0
// ============================================================================
module ddr2_init_seq
    import ddr2_pkg::*;
#(
    parameter int                   BA_BITS    = 3,
    parameter int                   ADDR_BITS  = 14,
    parameter int                   RANKS      = 1,
    parameter int                   T_PWR_CYC  = 40000,
    parameter int                   T_CKE_CYC  = 100,
    parameter int                   T_RP_CYC   = 3,
    parameter int                   T_MRD_CYC  = 2,
    parameter int                   T_RFC_CYC  = 26,
    parameter int                   T_DLLK_CYC = 200,
    parameter logic [ADDR_BITS-1:0] MR_INIT    = 'h0432,
    parameter logic [ADDR_BITS-1:0] EMR1_INIT  = 'h0008,
    parameter logic [ADDR_BITS-1:0] EMR2_INIT  = '0,
    parameter logic [ADDR_BITS-1:0] EMR3_INIT  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_init_start,
    input  logic                 i_upd_req,
    input  logic [1:0]           i_upd_sel,
    input  logic [ADDR_BITS-1:0] i_upd_val,
    output logic                 o_upd_ack,
    output logic                 o_init_cke,
    output logic [RANKS-1:0]     o_init_cs_n,
    output logic [3:0]           o_init_cmd,
    output logic [BA_BITS-1:0]   o_init_ba,
    output logic [ADDR_BITS-1:0] o_init_addr,
    output logic                 o_init_done,
    output logic                 o_busy
);

    localparam int T_MAX = max2(max2(max2(T_PWR_CYC, T_CKE_CYC), max2(T_RP_CYC, T_MRD_CYC)),
                                max2(T_RFC_CYC, T_DLLK_CYC));
    localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int DW = (T_DLLK_CYC > 0) ? $clog2(T_DLLK_CYC + 1) : 1;

    localparam logic [DW-1:0]        DLLK_MAX  = DW'(T_DLLK_CYC);
    localparam logic [3:0]           NUM_STEPS = 4'd11;
    localparam logic [ADDR_BITS-1:0] ADDR_A10  = ADDR_BITS'(1) << A10_AP;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PWR     = 3'd1,
        S_CKE     = 3'd2,
        S_SEQ     = 3'd3,
        S_DONE    = 3'd4,
        S_UPD_PRE = 3'd5,
        S_UPD_LM  = 3'd6
    } state_e;

    state_e                r_state;
    logic [3:0]            r_step;
    logic [DW-1:0]         r_dllk;
    logic                  r_cke;
    logic [RANKS-1:0]      r_cs_n;
    logic [3:0]            r_cmd;
    logic [BA_BITS-1:0]    r_ba;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_upd_ack;
    logic [ADDR_BITS-1:0]  r_mr;
    logic [ADDR_BITS-1:0]  r_emr1;
    logic [ADDR_BITS-1:0]  r_emr2;
    logic [ADDR_BITS-1:0]  r_emr3;

    logic [3:0]            w_cmd;
    logic [BA_BITS-1:0]    w_ba;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [TW-1:0]         w_gap;
    logic                  w_dll_rst;
    logic                  w_tmr_load;
    logic [TW-1:0]         w_tmr_val;
    logic                  w_tmr_zero;
    logic                  w_dllk_ok;
    logic                  w_upd_go;

    ddr2_cmd_timer #(
        .WIDTH (TW)
    ) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    assign w_dllk_ok = (int'(r_dllk) + 1) >= T_DLLK_CYC;
    // The ack cycle still sees the old request; do not restart on it
    assign w_upd_go  = i_upd_req && !r_upd_ack;

    // Init command table indexed by step
    always_comb begin
        w_cmd     = CMD_NOP;
        w_ba      = r_ba;
        w_addr    = '0;
        w_gap     = TW'(T_MRD_CYC - 1);
        w_dll_rst = 1'b0;
        case (r_step)
            4'd0, 4'd5: begin
                w_cmd  = CMD_PRE;
                w_ba   = '0;
                w_addr = ADDR_A10;
                w_gap  = TW'(T_RP_CYC - 1);
            end
            4'd1: begin
                w_cmd      = CMD_LM;
                w_ba       = '0;
                w_ba[1:0]  = SEL_EMR2;
                w_addr     = r_emr2;
            end
            4'd2: begin
                w_cmd      = CMD_LM;
                w_ba       = '0;
                w_ba[1:0]  = SEL_EMR3;
                w_addr     = r_emr3;
            end
            4'd3: begin
                w_cmd      = CMD_LM;
                w_ba       = '0;
                w_ba[1:0]  = SEL_EMR1;
                w_addr     = r_emr1;
                w_addr[0]  = 1'b0;
            end
            4'd4: begin
                w_cmd              = CMD_LM;
                w_ba               = '0;
                w_ba[1:0]          = SEL_MR;
                w_addr             = r_mr;
                w_addr[A8_DLL_RST] = 1'b1;
                w_dll_rst          = 1'b1;
            end
            4'd6, 4'd7: begin
                w_cmd = CMD_AREF;
                w_gap = TW'(T_RFC_CYC - 1);
            end
            4'd8: begin
                w_cmd              = CMD_LM;
                w_ba               = '0;
                w_ba[1:0]          = SEL_MR;
                w_addr             = r_mr;
                w_addr[A8_DLL_RST] = 1'b0;
            end
            4'd9: begin
                w_cmd                     = CMD_LM;
                w_ba                      = '0;
                w_ba[1:0]                 = SEL_EMR1;
                w_addr                    = r_emr1;
                w_addr[A9_7_OCD +: OCD_W] = '1;
            end
            4'd10: begin
                w_cmd                     = CMD_LM;
                w_ba                      = '0;
                w_ba[1:0]                 = SEL_EMR1;
                w_addr                    = r_emr1;
                w_addr[A9_7_OCD +: OCD_W] = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (i_init_start) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(T_PWR_CYC - 1);
                end
            end
            S_PWR: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(T_CKE_CYC - 1);
                end
            end
            S_CKE: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_gap;
                end
            end
            S_SEQ: begin
                if (w_tmr_zero && (r_step != NUM_STEPS)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_gap;
                end
            end
            S_DONE: begin
                if (i_init_start) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(T_PWR_CYC - 1);
                end else if (w_upd_go) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(T_RP_CYC - 1);
                end
            end
            S_UPD_PRE: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(T_MRD_CYC - 1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_dllk    <= '0;
            r_cke     <= 1'b0;
            r_cs_n    <= '1;
            r_cmd     <= CMD_NOP;
            r_ba      <= '0;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_upd_ack <= 1'b0;
            r_mr      <= MR_INIT;
            r_emr1    <= EMR1_INIT;
            r_emr2    <= EMR2_INIT;
            r_emr3    <= EMR3_INIT;
        end else begin
            r_cmd     <= CMD_NOP;
            r_cs_n    <= '1;
            r_addr    <= '0;
            r_upd_ack <= 1'b0;
            if (r_dllk != DLLK_MAX) begin
                r_dllk <= r_dllk + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_init_start) begin
                        r_busy  <= 1'b1;
                        r_step  <= '0;
                        r_state <= S_PWR;
                    end
                end
                S_PWR: begin
                    if (w_tmr_zero) begin
                        r_cke   <= 1'b1;
                        r_state <= S_CKE;
                    end
                end
                S_CKE, S_SEQ: begin
                    if (w_tmr_zero) begin
                        if (r_step == NUM_STEPS) begin
                            if (w_dllk_ok) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_cmd   <= w_cmd;
                            r_cs_n  <= {RANKS{w_cmd[3]}};
                            r_ba    <= w_ba;
                            r_addr  <= w_addr;
                            r_step  <= r_step + 4'd1;
                            r_state <= S_SEQ;
                            if (w_dll_rst) begin
                                r_dllk <= '0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (i_init_start) begin
                        r_done  <= 1'b0;
                        r_cke   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_step  <= '0;
                        r_state <= S_PWR;
                    end else if (w_upd_go) begin
                        r_busy  <= 1'b1;
                        r_cmd   <= CMD_PRE;
                        r_cs_n  <= '0;
                        r_ba    <= '0;
                        r_addr  <= ADDR_A10;
                        r_state <= S_UPD_PRE;
                    end
                end
                S_UPD_PRE: begin
                    if (w_tmr_zero) begin
                        r_cmd   <= CMD_LM;
                        r_cs_n  <= '0;
                        r_ba    <= BA_BITS'(i_upd_sel);
                        r_addr  <= i_upd_val;
                        r_state <= S_UPD_LM;
                        case (mr_sel_e'(i_upd_sel))
                            SEL_MR:   r_mr   <= i_upd_val;
                            SEL_EMR1: r_emr1 <= i_upd_val;
                            SEL_EMR2: r_emr2 <= i_upd_val;
                            default:  r_emr3 <= i_upd_val;
                        endcase
                    end
                end
                S_UPD_LM: begin
                    if (w_tmr_zero) begin
                        r_upd_ack <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_upd_ack   = r_upd_ack;
    assign o_init_cke  = r_cke;
    assign o_init_cs_n = r_cs_n;
    assign o_init_cmd  = r_cmd;
    assign o_init_ba   = r_ba;
    assign o_init_addr = r_addr;
    assign o_init_done = r_done;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_init_seq
// Description : Directed self-checking bench for the DDR2 init sequencer.
// Revision    : 1.0
// ============================================================================
module tb_ddr2_init_seq;

    localparam int BA = 3;
    localparam int AB = 14;
    localparam int RK = 2;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LM   = 4'b0000;

    logic          clk;
    logic          rst_n;
    logic          i_init_start;
    logic          i_upd_req;
    logic [1:0]    i_upd_sel;
    logic [AB-1:0] i_upd_val;
    logic          o_upd_ack;
    logic          o_init_cke;
    logic [RK-1:0] o_init_cs_n;
    logic [3:0]    o_init_cmd;
    logic [BA-1:0] o_init_ba;
    logic [AB-1:0] o_init_addr;
    logic          o_init_done;
    logic          o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ddr2_init_seq #(
        .BA_BITS    (BA),
        .ADDR_BITS  (AB),
        .RANKS      (RK),
        .T_PWR_CYC  (20),
        .T_CKE_CYC  (4),
        .T_DLLK_CYC (200)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_init_start (i_init_start),
        .i_upd_req    (i_upd_req),
        .i_upd_sel    (i_upd_sel),
        .i_upd_val    (i_upd_val),
        .o_upd_ack    (o_upd_ack),
        .o_init_cke   (o_init_cke),
        .o_init_cs_n  (o_init_cs_n),
        .o_init_cmd   (o_init_cmd),
        .o_init_ba    (o_init_ba),
        .o_init_addr  (o_init_addr),
        .o_init_done  (o_init_done),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cmd(output int at, output logic [3:0] c, output logic [BA-1:0] b,
                            output logic [AB-1:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_init_cmd == NOP && n < 2000);
        at = cyc;
        c  = o_init_cmd;
        b  = o_init_ba;
        a  = o_init_addr;
    endtask

    // Full init sequence from the cycle busy rose; returns DLL-reset and done cycles
    task automatic run_seq(input string tg, input logic [AB-1:0] mr, input logic [AB-1:0] emr1,
                           input int s, output int dll, output int d);
        logic [3:0]    e_cmd [11];
        int            e_gap [11];
        logic [BA-1:0] e_ba  [11];
        logic [AB-1:0] e_adr [11];
        int            at, prev, ncmd, n;
        logic [3:0]    c;
        logic [BA-1:0] b;
        logic [AB-1:0] a;
        e_cmd = '{PRE, LM, LM, LM, LM, PRE, AREF, AREF, LM, LM, LM};
        e_gap = '{4, 3, 2, 2, 2, 2, 3, 26, 26, 2, 2};
        e_ba  = '{0, 2, 3, 1, 0, 0, 0, 0, 0, 1, 1};
        e_adr = '{14'h0400, 14'h0000, 14'h0000, emr1 & ~14'h0001, mr | 14'h0100, 14'h0400,
                  14'h0000, 14'h0000, mr & ~14'h0100, emr1 | 14'h0380, emr1 & ~14'h0380};
        ncmd = 0;
        n    = 0;
        while (!o_init_cke && n < 1000) begin
            if (o_init_cmd != NOP) ncmd++;
            @(negedge clk);
            n++;
        end
        chk({tg, "_cke_rise"}, cyc - s, 20);
        chk({tg, "_cmd_in_pwr"}, ncmd, 0);
        prev = cyc;
        dll  = 0;
        for (int i = 0; i < 11; i++) begin
            next_cmd(at, c, b, a);
            chk($sformatf("%s_s%0d_gap", tg, i), at - prev, e_gap[i]);
            chk($sformatf("%s_s%0d_cmd", tg, i), c, e_cmd[i]);
            chk($sformatf("%s_s%0d_addr", tg, i), a, e_adr[i]);
            if (e_cmd[i] == LM) chk($sformatf("%s_s%0d_ba", tg, i), b, e_ba[i]);
            if (i == 0) chk({tg, "_cs_n_cmd"}, o_init_cs_n, 0);
            if (i == 4) dll = at;
            prev = at;
        end
        n = 0;
        while (!o_init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        d = cyc;
        chk({tg, "_dllk_to_done"}, d - dll, 200);
        chk({tg, "_busy_at_done"}, o_busy, 0);
        chk({tg, "_cs_n_nop"}, o_init_cs_n, 2'b11);
    endtask

    task automatic serve_upd(input string tg, input int exp_pre, input logic [1:0] sel,
                             input logic [AB-1:0] val);
        int            at, lm, n;
        logic [3:0]    c;
        logic [BA-1:0] b;
        logic [AB-1:0] a;
        next_cmd(at, c, b, a);
        chk({tg, "_pre_cyc"}, at, exp_pre);
        chk({tg, "_pre_cmd"}, c, PRE);
        chk({tg, "_pre_addr"}, a, 14'h0400);
        chk({tg, "_busy"}, o_busy, 1);
        next_cmd(lm, c, b, a);
        chk({tg, "_lm_gap"}, lm - at, 3);
        chk({tg, "_lm_cmd"}, c, LM);
        chk({tg, "_lm_ba"}, b, BA'(sel));
        chk({tg, "_lm_addr"}, a, val);
        n = 0;
        while (!o_upd_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tg, "_ack_lat"}, cyc - lm, 2);
        chk({tg, "_ack_busy"}, o_busy, 0);
        chk({tg, "_ack_done"}, o_init_done, 1);
        i_upd_req = 1'b0;
        @(negedge clk);
        chk({tg, "_ack_pulse"}, o_upd_ack, 0);
        chk({tg, "_idle_busy"}, o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, dll, d, at, n, nc, nb;
        logic [3:0]    c;
        logic [BA-1:0] b;
        logic [AB-1:0] a;

        rst_n        = 1'b0;
        i_init_start = 1'b0;
        i_upd_req    = 1'b0;
        i_upd_sel    = 2'd0;
        i_upd_val    = '0;
        repeat (2) @(negedge clk);
        chk("rst_cke", o_init_cke, 0);
        chk("rst_cmd", o_init_cmd, NOP);
        chk("rst_cs_n", o_init_cs_n, 2'b11);
        chk("rst_ba", o_init_ba, 0);
        chk("rst_addr", o_init_addr, 0);
        chk("rst_done", o_init_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ack", o_upd_ack, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_cmd", o_init_cmd, NOP);

        // First initialisation
        i_init_start = 1'b1;
        @(negedge clk);
        s = cyc;
        i_init_start = 1'b0;
        chk("init1_busy", o_busy, 1);
        chk("init1_cke_low", o_init_cke, 0);
        run_seq("init1", 14'h0432, 14'h0008, s, dll, d);

        // Runtime MR update
        i_upd_req = 1'b1;
        i_upd_sel = 2'd0;
        i_upd_val = 14'h0442;
        serve_upd("upd1", cyc + 1, 2'd0, 14'h0442);

        // Re-init with a simultaneous update request: re-init wins
        i_init_start = 1'b1;
        i_upd_req    = 1'b1;
        i_upd_sel    = 2'd1;
        i_upd_val    = 14'h0018;
        @(negedge clk);
        s = cyc;
        i_init_start = 1'b0;
        chk("reinit_done_low", o_init_done, 0);
        chk("reinit_cke_low", o_init_cke, 0);
        chk("reinit_busy", o_busy, 1);
        run_seq("reinit", 14'h0442, 14'h0008, s, dll, d);
        chk("reinit_no_ack", o_upd_ack, 0);
        serve_upd("upd2", d + 1, 2'd1, 14'h0018);

        // Reset in the middle of the first AREF gap
        i_init_start = 1'b1;
        @(negedge clk);
        i_init_start = 1'b0;
        for (int i = 0; i < 7; i++) next_cmd(at, c, b, a);
        chk("mid_aref_cmd", c, AREF);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cke", o_init_cke, 0);
        chk("arst_cmd", o_init_cmd, NOP);
        chk("arst_cs_n", o_init_cs_n, 2'b11);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_init_done, 0);
        chk("arst_ba", o_init_ba, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nc = 0;
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_init_cmd != NOP) nc++;
            if (o_busy) nb++;
        end
        chk("post_rst_cmds", nc, 0);
        chk("post_rst_busy", nb, 0);

        // init_start held high throughout; shadows back at reset values
        i_init_start = 1'b1;
        @(negedge clk);
        s = cyc;
        chk("held_busy", o_busy, 1);
        run_seq("held", 14'h0432, 14'h0008, s, dll, d);
        i_init_start = 1'b0;
        n  = 0;
        nb = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!o_init_done) n++;
            if (o_busy) nb++;
        end
        chk("held_done_stays", n, 0);
        chk("held_no_restart", nb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
